// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: FP exception flags, FPU sub-unit indices
// and the state type of the FP result collector.
package riscv_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    localparam int FpNumUnits = 4;
    localparam int FpUnitCmp  = 0;
    localparam int FpUnitAdd  = 1;
    localparam int FpUnitMul  = 2;
    localparam int FpUnitDiv  = 3;

    // ARB picks a new winner every cycle; HOLD freezes it under backpressure.
    typedef enum logic {
        COLL_ARB  = 1'b0,
        COLL_HOLD = 1'b1
    } coll_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin pick: first asserted request at or above
// base, searching upward with wrap-around.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] base,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IW = $clog2(N);

    // One spare bit so base+i can be wrapped for non-power-of-two N.
    logic [IW:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, base} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
            if (!gnt_valid && req[cand[IW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// Funnels one-cycle completion pulses from the non-stallable FP sub-units into
// a single backpressured writeback port, accumulating fflags on retirement.
module fp_result_collector
    import riscv_pkg::*;
#(
    parameter int NUM_UNITS = FpNumUnits,
    parameter int RD_W      = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_UNITS-1:0]      i_unit_valid,
    input  logic [NUM_UNITS*32-1:0]   i_unit_result,
    input  logic [NUM_UNITS-1:0]      i_unit_is_int,
    input  logic [NUM_UNITS*5-1:0]    i_unit_flags,
    input  logic [NUM_UNITS*RD_W-1:0] i_unit_rd,
    output logic [NUM_UNITS-1:0]      o_slot_full,
    output logic                      o_wb_valid,
    input  logic                      i_wb_ready,
    output logic [31:0]               o_wb_data,
    output logic                      o_wb_is_int,
    output logic [RD_W-1:0]           o_wb_rd,
    output logic [4:0]                o_wb_flags,
    input  logic                      i_fflags_wr,
    input  logic [4:0]                i_fflags_wdata,
    output logic [4:0]                o_fflags,
    output logic                      o_overflow
);
    localparam int IW = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0] slot_full;
    logic [NUM_UNITS-1:0] slot_is_int;
    logic [31:0]          slot_data  [NUM_UNITS];
    fp_flags_t            slot_flags [NUM_UNITS];
    logic [RD_W-1:0]      slot_rd    [NUM_UNITS];

    coll_state_e          state, state_nxt;
    logic [IW-1:0]        hold_idx, hold_idx_nxt;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        arb_idx, grant;
    logic                 arb_valid, wb_valid, handshake;
    logic [NUM_UNITS-1:0] retire;
    logic [4:0]           fflags, retire_flags;
    logic                 overflow, drop;

    rr_arbiter #(.N(NUM_UNITS)) u_arb (
        .req       (slot_full),
        .base      (rr_ptr),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    always_comb begin
        state_nxt    = state;
        hold_idx_nxt = hold_idx;
        grant        = arb_idx;
        wb_valid     = arb_valid;
        unique case (state)
            COLL_ARB: begin
                if (arb_valid && !i_wb_ready) begin
                    state_nxt    = COLL_HOLD;
                    hold_idx_nxt = arb_idx;
                end
            end
            COLL_HOLD: begin
                grant    = hold_idx;
                wb_valid = slot_full[hold_idx];
                if (i_wb_ready) state_nxt = COLL_ARB;
            end
            default: state_nxt = COLL_ARB;
        endcase
        handshake = wb_valid && i_wb_ready;
        for (int k = 0; k < NUM_UNITS; k++) begin
            retire[k] = handshake && (grant == IW'(k));
        end
    end

    assign drop         = |(i_unit_valid & slot_full & ~retire);
    assign retire_flags = handshake ? slot_flags[grant] : 5'b0;

    // A retiring slot may be refilled in the same cycle; retirement clears first.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            slot_full   <= '0;
            slot_is_int <= '0;
            for (int k = 0; k < NUM_UNITS; k++) begin
                slot_data[k]  <= '0;
                slot_flags[k] <= '0;
                slot_rd[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (i_unit_valid[k] && (!slot_full[k] || retire[k])) begin
                    slot_full[k]   <= 1'b1;
                    slot_is_int[k] <= i_unit_is_int[k];
                    slot_data[k]   <= i_unit_result[32*k +: 32];
                    slot_flags[k]  <= fp_flags_t'(i_unit_flags[5*k +: 5]);
                    slot_rd[k]     <= i_unit_rd[RD_W*k +: RD_W];
                end else if (retire[k]) begin
                    slot_full[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= COLL_ARB;
            hold_idx <= '0;
            rr_ptr   <= '0;
            fflags   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_idx <= hold_idx_nxt;
            if (handshake) begin
                rr_ptr <= (grant == IW'(NUM_UNITS-1)) ? '0 : grant + 1'b1;
            end
            // CSR write lands first, so a same-cycle retirement still ORs in.
            fflags   <= (i_fflags_wr ? i_fflags_wdata : fflags) | retire_flags;
            if (drop) overflow <= 1'b1;
        end
    end

    assign o_slot_full = slot_full;
    assign o_wb_valid  = wb_valid;
    assign o_wb_data   = wb_valid ? slot_data[grant]   : 32'b0;
    assign o_wb_is_int = wb_valid ? slot_is_int[grant] : 1'b0;
    assign o_wb_rd     = wb_valid ? slot_rd[grant]     : '0;
    assign o_wb_flags  = wb_valid ? slot_flags[grant]  : 5'b0;
    assign o_fflags    = fflags;
    assign o_overflow  = overflow;

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed and randomized checks of fp_result_collector against a
// behavioural slot/round-robin reference model.
module tb_fp_result_collector;
    localparam int N  = 4;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    unit_valid;
    logic [N*32-1:0] unit_result;
    logic [N-1:0]    unit_is_int;
    logic [N*5-1:0]  unit_flags;
    logic [N*RW-1:0] unit_rd;
    logic [N-1:0]    slot_full;
    logic            wb_valid;
    logic            wb_ready;
    logic [31:0]     wb_data;
    logic            wb_is_int;
    logic [RW-1:0]   wb_rd;
    logic [4:0]      wb_flags;
    logic            fflags_wr;
    logic [4:0]      fflags_wdata;
    logic [4:0]      fflags;
    logic            overflow;

    fp_result_collector #(.NUM_UNITS(N), .RD_W(RW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_unit_valid   (unit_valid),
        .i_unit_result  (unit_result),
        .i_unit_is_int  (unit_is_int),
        .i_unit_flags   (unit_flags),
        .i_unit_rd      (unit_rd),
        .o_slot_full    (slot_full),
        .o_wb_valid     (wb_valid),
        .i_wb_ready     (wb_ready),
        .o_wb_data      (wb_data),
        .o_wb_is_int    (wb_is_int),
        .o_wb_rd        (wb_rd),
        .o_wb_flags     (wb_flags),
        .i_fflags_wr    (fflags_wr),
        .i_fflags_wdata (fflags_wdata),
        .o_fflags       (fflags),
        .o_overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per-unit pending result, round-robin pointer, and a
    // "locked" offer that must repeat until accepted.
    bit          m_full [N];
    logic [31:0] m_data [N];
    logic        m_int  [N];
    logic [4:0]  m_flg  [N];
    logic [4:0]  m_rd   [N];
    int          m_rr;
    bit          m_locked;
    int          m_lock;
    logic [4:0]  m_ff;
    bit          m_ovf;

    logic [RW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_full[k] = 0;
            m_data[k] = '0;
            m_int[k]  = 0;
            m_flg[k]  = '0;
            m_rd[k]   = '0;
        end
        m_rr = 0; m_locked = 0; m_lock = 0; m_ff = '0; m_ovf = 0;
    endtask

    task automatic pulse(input int k, input logic [31:0] d, input logic ii,
                         input logic [4:0] f, input logic [4:0] r);
        unit_valid[k]          = 1'b1;
        unit_result[32*k +: 32] = d;
        unit_is_int[k]         = ii;
        unit_flags[5*k +: 5]   = f;
        unit_rd[RW*k +: RW]    = r;
    endtask

    // Called at the negedge with inputs set: check outputs, advance model, clock.
    task automatic cycle();
        bit v;
        int g;
        bit hs;
        logic [N-1:0] ef;
        logic [RW-1:0] e;
        v = 0; g = 0;
        if (m_locked) begin
            v = 1; g = m_lock;
        end else begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_rr + i) % N;
                if (!v && m_full[j]) begin v = 1; g = j; end
            end
        end
        for (int k = 0; k < N; k++) ef[k] = m_full[k];
        chk("wb_valid",  64'(wb_valid),  64'(v));
        chk("wb_data",   64'(wb_data),   v ? 64'(m_data[g]) : 64'd0);
        chk("wb_is_int", 64'(wb_is_int), v ? 64'(m_int[g])  : 64'd0);
        chk("wb_rd",     64'(wb_rd),     v ? 64'(m_rd[g])   : 64'd0);
        chk("wb_flags",  64'(wb_flags),  v ? 64'(m_flg[g])  : 64'd0);
        chk("slot_full", 64'(slot_full), 64'(ef));
        chk("fflags",    64'(fflags),    64'(m_ff));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        if (wb_valid && wb_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("retire_order", 64'(wb_rd), 64'(e));
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            hs   = v && wb_ready;
            m_ff = (fflags_wr ? fflags_wdata : m_ff) | (hs ? m_flg[g] : 5'b0);
            if (hs) m_full[g] = 0;
            for (int k = 0; k < N; k++) begin
                if (unit_valid[k]) begin
                    if (!m_full[k]) begin
                        m_full[k] = 1;
                        m_data[k] = unit_result[32*k +: 32];
                        m_int[k]  = unit_is_int[k];
                        m_flg[k]  = unit_flags[5*k +: 5];
                        m_rd[k]   = unit_rd[RW*k +: RW];
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (hs) m_rr = (g + 1) % N;
            m_locked = v && !wb_ready;
            if (m_locked) m_lock = g;
        end
        @(posedge clk);
        @(negedge clk);
        unit_valid = '0;
        fflags_wr  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; unit_valid = '0; unit_result = '0; unit_is_int = '0;
        unit_flags = '0; unit_rd = '0; wb_ready = 1'b0; fflags_wr = 1'b0;
        fflags_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();
        cycle();

        // Single result from unit 0.
        wb_ready = 1'b1;
        pulse(0, 32'h1, 1'b1, 5'b10000, 5'd7);
        cycle();
        chk("single_valid", 64'(wb_valid), 64'd1);
        chk("single_rd", 64'(wb_rd), 64'd7);
        cycle();
        chk("single_fflags", 64'(fflags), 64'h10);
        chk("single_empty", 64'(slot_full), 64'd0);

        // Round-robin from pointer 0 (last grant was unit 0 -> pointer is 1,
        // so first retire unit 1..3 then 0 would apply; realign with unit 3 first).
        pulse(3, 32'h33, 1'b0, 5'b0, 5'd3);
        cycle();
        cycle();
        for (int k = 0; k < N; k++) pulse(k, $urandom, 1'b0, 5'b0, 5'(k));
        for (int k = 0; k < N; k++) exp_q.push_back(5'(k));
        repeat (5) cycle();
        chk("rr0_drain", 64'(exp_q.size()), 64'd0);
        pulse(1, 32'h11, 1'b0, 5'b0, 5'd1);
        repeat (2) cycle();
        for (int k = 0; k < N; k++) pulse(k, $urandom, 1'b1, 5'b0, 5'(k));
        exp_q.push_back(5'd2); exp_q.push_back(5'd3);
        exp_q.push_back(5'd0); exp_q.push_back(5'd1);
        repeat (5) cycle();
        chk("rr2_drain", 64'(exp_q.size()), 64'd0);

        // Backpressure: unit 1 stays offered while unit 0 arrives.
        wb_ready = 1'b0;
        pulse(1, 32'hB1B1_0001, 1'b0, 5'b00100, 5'd21);
        cycle();
        pulse(0, 32'hA0A0_0000, 1'b1, 5'b00010, 5'd20);
        cycle();
        chk("bp_hold_data", 64'(wb_data), 64'hB1B1_0001);
        repeat (2) cycle();
        wb_ready = 1'b1;
        exp_q.push_back(5'd21); exp_q.push_back(5'd20);
        repeat (3) cycle();
        chk("bp_drain", 64'(exp_q.size()), 64'd0);

        // Overflow: second pulse into a stalled full slot is dropped.
        wb_ready = 1'b0;
        pulse(2, 32'hAAAA_0002, 1'b0, 5'b0, 5'd12);
        cycle();
        pulse(2, 32'hBBBB_0002, 1'b0, 5'b0, 5'd13);
        cycle();
        chk("ovf_set", 64'(overflow), 64'd1);
        wb_ready = 1'b1;
        chk("ovf_keep_old", 64'(wb_data), 64'hAAAA_0002);
        cycle();
        cycle();

        // Refill while retiring: no overflow, new data follows.
        do_reset();
        pulse(2, 32'hAAAA_0002, 1'b0, 5'b0, 5'd12);
        cycle();
        pulse(2, 32'hBBBB_0002, 1'b0, 5'b0, 5'd13);
        exp_q.push_back(5'd12); exp_q.push_back(5'd13);
        cycle();
        chk("refill_data", 64'(wb_data), 64'hBBBB_0002);
        cycle();
        chk("refill_no_ovf", 64'(overflow), 64'd0);

        // CSR write ordered before a same-cycle retirement.
        pulse(3, 32'h3, 1'b0, 5'b11110, 5'd3);
        cycle();
        cycle();
        pulse(3, 32'h4, 1'b0, 5'b00001, 5'd4);
        cycle();
        fflags_wr = 1'b1; fflags_wdata = 5'b00000;
        cycle();
        chk("fflags_order", 64'(fflags), 64'h01);

        // Reset mid-stream discards held results.
        wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) pulse(k, 32'hDEAD_0000 + 32'(k), 1'b1, 5'b11111, 5'(k));
        cycle();
        do_reset();
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_full", 64'(slot_full), 64'd0);
        wb_ready = 1'b1;
        repeat (3) cycle();

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            wb_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    d = $urandom;
                    pulse(k, d, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                fflags_wr = 1'b1;
                fflags_wdata = 5'($urandom_range(0, 31));
            end
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
            rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
# fp_result_collector

Collects completed results from the FPU's fixed-latency execution sub-units (compare/min-max, add/sub, multiply, divide/sqrt) and funnels them into a single writeback port with valid/ready backpressure. Each unit signals completion with a one-cycle valid pulse and cannot stall, so the block gives each unit a one-entry holding slot. A round-robin arbiter picks the next result to retire. The block also accumulates the architectural `fflags` from retired results and flags lost results.

## Interface
Parameters:
- `NUM_UNITS`, 4: number of FP sub-units feeding the collector (2..8).
- `RD_W`, 5: destination register tag width.

Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_unit_valid`  in  NUM_UNITS  one-cycle completion pulse per unit.
- `i_unit_result`  in  NUM_UNITS*32  result per unit; unit k occupies bits [32k+31:32k].
- `i_unit_is_int`  in  NUM_UNITS  result targets the integer register file (FEQ/FLT/FLE/FCLASS/FCVT.W).
- `i_unit_flags`  in  NUM_UNITS*5  `riscv_pkg::fp_flags_t` per unit.
- `i_unit_rd`  in  NUM_UNITS*RD_W  destination tag per unit.
- `o_slot_full`  out  NUM_UNITS  slot k occupied; issue logic must not launch on unit k unless the slot frees before completion.
- `o_wb_valid`  out  1  writeback request.
- `i_wb_ready`  in  1  writeback accept.
- `o_wb_data`  out  32  selected result.
- `o_wb_is_int`  out  1  integer-destination flag.
- `o_wb_rd`  out  RD_W  destination tag.
- `o_wb_flags`  out  5  flags of the selected result.
- `i_fflags_wr`  in  1  CSR write of fflags.
- `i_fflags_wdata`  in  5  CSR write data.
- `o_fflags`  out  5  accumulated exception flags.
- `o_overflow`  out  1  sticky: a result was dropped.

## Operation
- Slot k load: `i_unit_valid[k]` captures result, is_int, flags and rd, and sets occupancy. The load takes effect when the slot is empty, or when the slot is being retired in the same cycle (refill).
- Drop: a pulse into an occupied slot that is not retiring that cycle discards the new result. The slot keeps its old contents, and `o_overflow` is set and held until reset.
- Retire: a handshake (`o_wb_valid & i_wb_ready`) clears the granted slot.
- The FSM has two states:
  - ARB: the grant is the first occupied slot at or after `rr_ptr`, searching upward with wrap.
    - If no slot is occupied, `o_wb_valid`=0.
    - Valid without ready moves the FSM to HOLD and latches `hold_idx`.
  - HOLD: the grant is fixed to `hold_idx`. `i_wb_ready`=1 moves the FSM to ARB.
- `o_wb_*` stays stable while valid and not ready.
- `rr_ptr`: on every handshake it becomes (grant+1) mod NUM_UNITS.
- fflags update, per cycle:
  - `i_fflags_wr`=1: fflags ← `i_fflags_wdata` | (handshake ? `o_wb_flags` : 0).
  - Otherwise: fflags ← fflags | (handshake ? `o_wb_flags` : 0).
- A CSR write is therefore ordered before a same-cycle retirement.
- `o_wb_data`, `o_wb_is_int`, `o_wb_rd` and `o_wb_flags` are 0 whenever `o_wb_valid`=0.

## Timing
- Reset values: all slots empty, FSM=ARB, `rr_ptr`=0, and `o_wb_valid`, `o_wb_data`, `o_wb_is_int`, `o_wb_rd`, `o_wb_flags`, `o_slot_full`, `o_fflags`, `o_overflow` all 0.
- Latency: a pulse in cycle t gives `o_wb_valid`=1 in cycle t+1 if that slot wins arbitration. The output mux is combinational from registered slots, grant state and `rr_ptr`.
- Throughput: one retirement per cycle. A slot retired in cycle t can accept a refill pulse in the same cycle t.
- `o_slot_full` reflects registered occupancy and does not look ahead to the same-cycle drain.
- Reset asserted mid-operation: all held results are discarded and fflags clears on the next edge. Unit pulses in the reset cycle are ignored.
- Simultaneous pulses on all units are all captured (one slot each). They retire over NUM_UNITS cycles in round-robin order.
- The fflags update and the overflow set apply at the same edge as the triggering event.

## Structure
- `riscv_pkg` already holds `fp_flags_t` (nv, dz, of, uf, nx) and is reused.
- Add `FpNumUnits` and the unit index constants (`FpUnitCmp`=0, `FpUnitAdd`=1, `FpUnitMul`=2, `FpUnitDiv`=3) to `riscv_pkg`.
- One sub-module, `rr_arbiter`: a parameterised N-way round-robin priority pick from a request vector and a base pointer. It is combinational and reusable by the integer writeback merge.
- Slots, FSM, fflags and overflow are implemented inline.

## Test plan
- Single result: pulse unit 0 with result 0x00000001, is_int=1, rd=7, flags nv=1, `i_wb_ready`=1 → next cycle `o_wb_valid`=1 with data 0x1, rd 7. Afterwards `o_fflags`=5'b10000 and the slot is empty.
- Round-robin: pulse all four units in one cycle, ready held 1 → retire order 0,1,2,3. Repeat with `rr_ptr`=2 → order 2,3,0,1.
- Backpressure stability: unit 1 pending with ready=0, then unit 0 pulses → output stays unit 1's data and rd until ready. Unit 0 retires next.
- Overflow and refill:
  - Unit 2 slot full with ready=0, second pulse → `o_overflow`=1 and the original data retires.
  - Repeat with ready=1 in the pulse cycle → no overflow and the new data retires next cycle.
- fflags ordering: CSR write 5'b00000 in the same cycle as retiring flags nx=1 → `o_fflags`=5'b00001.
- Reset mid-stream: three slots full, `i_rst_n`=0 for one cycle → all outputs 0 next cycle and no retirement of the old results.
